// File: rtl/timer_pkg.sv
// Shared constants, state types and frame helpers for timer_uart_tx.
// Optional parity build: define TIMER_UART_PARITY_EN.
package timer_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 1250;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] LAST_BYTE = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT
  } seq_state_t;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_PARITY,
    B_STOP
  } ser_state_t;

  function automatic logic [7:0] tens(input logic [5:0] v);
    return ASCII_ZERO + {2'b00, v / 6'd10};
  endfunction

  function automatic logic [7:0] units(input logic [5:0] v);
    return ASCII_ZERO + {2'b00, v % 6'd10};
  endfunction

  // Byte idx of the "HH:MM:SS<flag>\r\n" report.
  function automatic logic [7:0] frame_byte(
    input logic [3:0] idx,
    input logic [5:0] h,
    input logic [5:0] m,
    input logic [5:0] s,
    input logic       flag
  );
    logic [7:0] b;
    unique case (idx)
      4'd0:    b = tens(h);
      4'd1:    b = units(h);
      4'd2:    b = ASCII_COLON;
      4'd3:    b = tens(m);
      4'd4:    b = units(m);
      4'd5:    b = ASCII_COLON;
      4'd6:    b = tens(s);
      4'd7:    b = units(s);
      4'd8:    b = flag ? ASCII_STAR : ASCII_SPACE;
      4'd9:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/timer_uart_tx_byte.sv
// One-byte UART serializer: start, 8 data LSB first, optional parity, stop.
// Parity bit present only when TIMER_UART_PARITY_EN is defined.
module uart_tx_byte
  import timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  ser_state_t  state;
  ser_state_t  state_n;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  data_q;
  logic        bit_end;

  assign bit_end = (cnt == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= B_IDLE;
    else       state <= state_n;
  end

  // baud counter, bit index and latched byte
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
    end else if (state == B_IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      if (start) data_q <= data;
    end else if (bit_end) begin
      cnt <= '0;
      if (state == B_DATA) bit_idx <= bit_idx + 3'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // next state and line level; byte_done marks the last stop cycle
  always_comb begin
    state_n   = state;
    tx        = 1'b1;
    byte_done = 1'b0;
    unique case (state)
      B_IDLE: begin
        if (start) state_n = B_START;
      end
      B_START: begin
        tx = 1'b0;
        if (bit_end) state_n = B_DATA;
      end
      B_DATA: begin
        tx = data_q[bit_idx];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef TIMER_UART_PARITY_EN
          state_n = B_PARITY;
`else
          state_n = B_STOP;
`endif
        end
      end
`ifdef TIMER_UART_PARITY_EN
      B_PARITY: begin
        tx = ^data_q;
        if (bit_end) state_n = B_STOP;
      end
`endif
      B_STOP: begin
        byte_done = bit_end;
        if (bit_end) state_n = B_IDLE;
      end
      default: state_n = B_IDLE;
    endcase
  end

endmodule

// File: rtl/timer_uart_tx.sv
// Sends an "HH:MM:SS<flag>\r\n" report over UART on request or timer expiry.
// Define TIMER_UART_PARITY_EN for an even-parity bit per byte.
module timer_uart_tx
  import timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [1:0] sel,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       done,
  output logic       tx,
  output logic       busy
);

  seq_state_t state;
  seq_state_t state_n;
  logic [3:0] byte_idx;
  logic       done_q;
  logic       armed;
  logic       busy_q;
  logic [5:0] snap_h;
  logic [5:0] snap_m;
  logic [5:0] snap_s;
  logic       snap_done;
  logic       trig;
  logic       accept;
  logic       start;
  logic       byte_done;
  logic       last_done;
  logic [7:0] data;

  // armed keeps a done level held across reset from looking like an edge
  assign trig      = (send && sel == 2'd2) || (done && !done_q && armed);
  assign accept    = trig && !busy_q;
  assign last_done = (state == S_WAIT) && byte_done
                     && (byte_idx == LAST_BYTE);
  assign busy      = busy_q;
  assign data      = frame_byte(byte_idx, snap_h, snap_m, snap_s, snap_done);

  // trigger detection, snapshot and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q    <= 1'b0;
      armed     <= 1'b0;
      busy_q    <= 1'b0;
      snap_h    <= '0;
      snap_m    <= '0;
      snap_s    <= '0;
      snap_done <= 1'b0;
    end else begin
      done_q <= done;
      armed  <= 1'b1;
      if (accept) begin
        busy_q    <= 1'b1;
        snap_h    <= hours;
        snap_m    <= minutes;
        snap_s    <= seconds;
        snap_done <= done;
      end else if (last_done) begin
        busy_q <= 1'b0;
      end
    end
  end

  // sequencer state and byte index
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_idx <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE) byte_idx <= '0;
      else if (state == S_WAIT && byte_done && !last_done)
        byte_idx <= byte_idx + 4'd1;
    end
  end

  // IDLE waits one cycle after accept so byte 0 starts on edge +2
  always_comb begin
    state_n = state;
    start   = 1'b0;
    unique case (state)
      S_IDLE: if (busy_q) state_n = S_LOAD;
      S_LOAD: begin
        start   = 1'b1;
        state_n = S_SEND;
      end
      S_SEND: state_n = S_WAIT;
      S_WAIT: begin
        if (byte_done) state_n = last_done ? S_IDLE : S_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_timer_uart_tx.sv
// Self-checking bench for timer_uart_tx with a waveform-level model.
// Build with TIMER_UART_PARITY_EN to exercise the parity variant.
module tb_timer_uart_tx;

  localparam int CPB = 4;
`ifdef TIMER_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_EDGES = 2 + 11 * NB * CPB + 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [1:0] sel;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       done;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit m_doneq;
  bit m_armed;
  bit m_trig;
  bit chk_en = 1'b0;
  bit cap_en = 1'b0;
  bit trace[$];
  logic [7:0] rx_bytes[$];
  bit rx_par[$];
  int rx_pos[$];

  always #5 clk = ~clk;

  timer_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .send   (send),
    .sel    (sel),
    .hours  (hours),
    .minutes(minutes),
    .seconds(seconds),
    .done   (done),
    .tx     (tx),
    .busy   (busy)
  );

  function automatic logic [10:0][7:0] frame_of(int h, int m, int s, bit d);
    logic [10:0][7:0] f;
    f[0]  = 8'(48 + h / 10);
    f[1]  = 8'(48 + h % 10);
    f[2]  = 8'h3A;
    f[3]  = 8'(48 + m / 10);
    f[4]  = 8'(48 + m % 10);
    f[5]  = 8'h3A;
    f[6]  = 8'(48 + s / 10);
    f[7]  = 8'(48 + s % 10);
    f[8]  = d ? 8'h2A : 8'h20;
    f[9]  = 8'h0D;
    f[10] = 8'h0A;
    return f;
  endfunction

  // expected line level for every cycle after the accepting edge
  function automatic void push_wave(logic [10:0][7:0] f);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) exp_q.push_back(1'b1);
      repeat (CPB) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        repeat (CPB) exp_q.push_back(f[k][b]);
`ifdef TIMER_UART_PARITY_EN
      repeat (CPB) exp_q.push_back(^f[k]);
`endif
      repeat (CPB) exp_q.push_back(1'b1);
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_doneq = 1'b0;
      m_armed = 1'b0;
    end else begin
      m_trig = (send && sel == 2'd2) || (done && !m_doneq && m_armed);
      if (exp_q.size() == 0) begin
        if (m_trig) push_wave(frame_of(hours, minutes, seconds, done));
      end else begin
        void'(exp_q.pop_front());
      end
      m_doneq = done;
      m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit etx;
      bit eb;
      eb  = (exp_q.size() != 0);
      etx = eb ? exp_q[0] : 1'b1;
      checks++;
      if (tx !== etx || busy !== eb) begin
        errors++;
        $display("FAIL model t=%0t: tx=%b busy=%b, want tx=%b busy=%b",
                 $time, tx, busy, etx, eb);
      end
    end
    if (cap_en) trace.push_back(tx === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic void decode();
    int i = 0;
    rx_bytes.delete();
    rx_par.delete();
    rx_pos.delete();
    while (i < trace.size()) begin
      if (trace[i] == 1'b0) begin
        logic [7:0] b;
        if (i + NB * CPB > trace.size()) break;
        for (int k = 0; k < 8; k++)
          b[k] = trace[i + CPB * (1 + k) + CPB / 2];
        rx_bytes.push_back(b);
        rx_pos.push_back(i);
        rx_par.push_back(trace[i + 9 * CPB + CPB / 2]);
        i += NB * CPB;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic check_frame(string name, logic [10:0][7:0] want);
    decode();
    chk({name, " byte count"}, rx_bytes.size(), 11);
    if (rx_bytes.size() == 11) begin
      for (int k = 0; k < 11; k++)
        chk($sformatf("%s byte %0d", name, k), rx_bytes[k], want[k]);
      for (int k = 1; k < 11; k++)
        chk($sformatf("%s spacing %0d", name, k),
            rx_pos[k] - rx_pos[k-1], NB * CPB + 1);
    end
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    chk({name, " idle timeout"}, busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0][7:0] lit;
    int n;
    int busy_cycles;
    reset = 1'b1; send = 1'b0; sel = 2'd0; done = 1'b1;
    hours = 6'd0; minutes = 6'd0; seconds = 6'd0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    reset = 1'b0;
    busy_cycles = 0;
    repeat (12) begin tick(); busy_cycles += busy; end
    chk("done held through reset", busy_cycles, 0);
    done = 1'b0;
    tick();

    // 12:34:56 on request, latency and busy length measured by hand
    hours = 6'd12; minutes = 6'd34; seconds = 6'd56; sel = 2'd2;
    trace.delete(); cap_en = 1'b1;
    send = 1'b1;
    tick();
    send = 1'b0;
    chk("accept busy", busy, 1);
    chk("edge+0 tx", tx, 1);
    tick();
    chk("edge+1 tx", tx, 1);
    tick();
    chk("edge+2 tx start", tx, 0);
    n = 2;
    while (busy && n < 3000) begin tick(); n++; end
    chk("busy length", n, FRAME_EDGES);
    cap_en = 1'b0;
    lit = {8'h0A, 8'h0D, 8'h20, 8'h36, 8'h35, 8'h3A,
           8'h34, 8'h33, 8'h3A, 8'h32, 8'h31};
    check_frame("f1", lit);
`ifdef TIMER_UART_PARITY_EN
    if (rx_par.size() == 11) begin
      chk("parity 0x31", rx_par[0], 1);
      chk("parity 0x33", rx_par[3], 0);
    end
`endif

    // send outside timer mode does nothing; done rise still reports
    hours = 6'd0; minutes = 6'd0; seconds = 6'd0; sel = 2'd0;
    send = 1'b1;
    busy_cycles = 0;
    repeat (20) begin tick(); busy_cycles += busy; end
    send = 1'b0;
    chk("sel0 send ignored", busy_cycles, 0);
    trace.delete(); cap_en = 1'b1;
    done = 1'b1;
    wait_idle("f2");
    cap_en = 1'b0;
    lit = {8'h0A, 8'h0D, 8'h2A, 8'h30, 8'h30, 8'h3A,
           8'h30, 8'h30, 8'h3A, 8'h30, 8'h30};
    check_frame("f2", lit);
    done = 1'b0;
    tick();

    // inputs and triggers during a frame leave it untouched
    hours = 6'd7; minutes = 6'd8; seconds = 6'd9; sel = 2'd2;
    trace.delete(); cap_en = 1'b1;
    send = 1'b1;
    tick();
    send = 1'b0;
    hours = 6'd23; minutes = 6'd59; seconds = 6'd59;
    for (int i = 0; i < 200; i++) begin
      send = (i % 37 == 0);
      done = (i > 100);
      tick();
    end
    send = 1'b0;
    wait_idle("f3");
    busy_cycles = 0;
    repeat (40) begin tick(); busy_cycles += busy; end
    cap_en = 1'b0;
    chk("no second frame", busy_cycles, 0);
    lit = {8'h0A, 8'h0D, 8'h20, 8'h39, 8'h30, 8'h3A,
           8'h38, 8'h30, 8'h3A, 8'h37, 8'h30};
    check_frame("f3", lit);
    done = 1'b0;

    // reset in the middle of a data bit of byte 3
    hours = 6'd12; minutes = 6'd34; seconds = 6'd56;
    send = 1'b1;
    tick();
    send = 1'b0;
    repeat (2 + 3 * (NB * CPB + 1) + 3 * CPB + 1) tick();
    chk("mid frame busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("abort tx", tx, 1);
    chk("abort busy", busy, 0);
    reset = 1'b0;
    tick();
    trace.delete(); cap_en = 1'b1;
    send = 1'b1;
    tick();
    send = 1'b0;
    wait_idle("f4");
    cap_en = 1'b0;
    lit = {8'h0A, 8'h0D, 8'h20, 8'h36, 8'h35, 8'h3A,
           8'h34, 8'h33, 8'h3A, 8'h32, 8'h31};
    check_frame("f4", lit);

    // randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      send    = ($urandom_range(0, 15) == 0);
      sel     = 2'($urandom_range(0, 3));
      hours   = 6'($urandom_range(0, 63));
      minutes = 6'($urandom_range(0, 63));
      seconds = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 60) == 0) done = ~done;
      reset   = ($urandom_range(0, 1500) == 0);
      tick();
    end
    reset = 1'b0;
    send  = 1'b0;
    repeat (600) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_uart_tx.md
TIMER_UART_TX -- requirements
Module: timer_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 1250, clk cycles per UART bit (12 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: send  input  1  report request; only honoured in the cycle sel == 2'd2.
REQ-005 SHALL have port: sel  input  2  mode select; 2'd2 = timer mode.
REQ-006 SHALL have port: hours  input  6  timer hours, binary.
REQ-007 SHALL have port: minutes  input  6  timer minutes, binary.
REQ-008 SHALL have port: seconds  input  6  timer seconds, binary.
REQ-009 SHALL have port: done  input  1  timer-expired flag.
REQ-010 SHALL have port: tx  output  1  UART serial line, idle high.
REQ-011 SHALL have port: busy  output  1  high while a report frame is in progress.

Function
REQ-012 SHALL register done each cycle; auto-trigger = done & ~done_q (rising edge), accepted regardless of sel.
REQ-013 SHALL accept a trigger (send & sel==2'd2, or auto-trigger) only while busy == 0; triggers while busy are dropped, not queued.
REQ-014 SHALL treat simultaneous send and auto-trigger as one frame.
REQ-015 SHALL snapshot hours, minutes, seconds, done on the accepting edge; later input changes SHALL NOT affect the frame.
REQ-016 SHALL raise busy on the accepting edge and drop it on the edge that ends the stop bit of the last byte.
REQ-017 SHALL send an 11-byte frame: H-tens, H-units, ':', M-tens, M-units, ':', S-tens, S-units, flag, 0x0D, 0x0A.
REQ-018 SHALL set flag = '*' (0x2A) if snapshot done = 1, else ' ' (0x20).
REQ-019 SHALL produce digit = 0x30 + (v / 10) and 0x30 + (v % 10) for v = 0..63; no clamping (62 -> "62").
REQ-020 SHALL frame each byte as start bit 0, 8 data bits LSB first, [parity], stop bit 1; every bit lasts exactly CLKS_PER_BIT cycles.
REQ-021 SHALL drive the start bit of byte 0 beginning on the 2nd rising edge after the accepting edge.
REQ-022 SHALL insert exactly 1 idle-high cycle between the stop bit of one byte and the start bit of the next.
REQ-023 SHALL sequence with states IDLE -> LOAD -> SEND -> WAIT -> (LOAD for byte_idx < 10, else IDLE); byte_idx is 4 bits, cleared in IDLE.
REQ-024 SHALL hold tx = 1 whenever no bit is being driven.

Reset
REQ-025 SHALL, on reset = 1 at a clock edge, force tx = 1, busy = 0, state IDLE, byte_idx = 0, bit and baud counters = 0, done_q = 0, snapshot = 0, abandoning any partial frame.
REQ-026 SHALL NOT generate an auto-trigger on the first cycle after reset when done is already 1 (done_q loads done in that cycle).

Configuration
REQ-027 SHALL, when TIMER_UART_PARITY_EN is defined, insert one even-parity bit (XOR of the 8 data bits) between data and stop, giving 11 bit-times per byte.
REQ-028 SHALL, when TIMER_UART_PARITY_EN is undefined, send 8N1 (10 bit-times per byte) with no parity logic.

Structure
REQ-029 SHALL place in shared package timer_pkg: ASCII constants (colon, space, star, CR, LF, digit zero), default CLKS_PER_BIT, sequencer state enum, serializer state enum.
REQ-030 SHALL instantiate one sub-module uart_tx_byte (byte serializer: IDLE/START/DATA/PARITY/STOP, inputs start and data[7:0], outputs tx and byte_done pulse).

Verification (CLKS_PER_BIT = 4)
REQ-031 SHALL check: reset held 3 cycles -> tx = 1, busy = 0; still so with done = 1 held through reset release.
REQ-032 SHALL check: 12:34:56, done = 0, sel = 2, send pulse -> bytes 31 32 3A 33 34 3A 35 36 20 0D 0A; start bit at edge +2; busy low after the last stop bit.
REQ-033 SHALL check: sel = 0, done 0 -> 1 at 00:00:00 -> frame 30 30 3A 30 30 3A 30 30 2A 0D 0A; send with sel = 0 -> no activity.
REQ-034 SHALL check: during a frame, send pulses and input change to 23:59:59 -> frame unchanged, no second frame.
REQ-035 SHALL check: reset asserted mid data-bit of byte 3 -> tx = 1, busy = 0 on the next edge; a new send then yields a full correct frame.
REQ-036 SHALL check: with TIMER_UART_PARITY_EN, byte 0x31 -> parity bit 1; byte 0x33 -> parity bit 0; byte spacing 11 bit-times + 1 cycle.
